// File: rtl/alu_unit_pkg.sv
// Shared definitions for the ALU execution unit: datapath widths, ROB tag
// constants, decoded op codes, FSM state and shift-kind encodings.
package alu_unit_pkg;

  localparam int DATALEN  = 32;
  localparam int ROBINDEX = 5;
  localparam int OPLEN    = 6;
  localparam int IMMLEN   = 32;
  localparam int ADDR     = 32;

  // ROB has 16 entries (tags 0..15); the MSB-only tag means "no destination".
  localparam logic [ROBINDEX-1:0] ROBNOTRENAME = 5'b10000;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [OPLEN-1:0] OP_NOP   = 6'd0;
  localparam logic [OPLEN-1:0] OP_LUI   = 6'd1;
  localparam logic [OPLEN-1:0] OP_AUIPC = 6'd2;
  localparam logic [OPLEN-1:0] OP_JAL   = 6'd3;
  localparam logic [OPLEN-1:0] OP_JALR  = 6'd4;
  localparam logic [OPLEN-1:0] OP_BEQ   = 6'd5;
  localparam logic [OPLEN-1:0] OP_BNE   = 6'd6;
  localparam logic [OPLEN-1:0] OP_BLT   = 6'd7;
  localparam logic [OPLEN-1:0] OP_BGE   = 6'd8;
  localparam logic [OPLEN-1:0] OP_BLTU  = 6'd9;
  localparam logic [OPLEN-1:0] OP_BGEU  = 6'd10;
  localparam logic [OPLEN-1:0] OP_ADD   = 6'd11;
  localparam logic [OPLEN-1:0] OP_SUB   = 6'd12;
  localparam logic [OPLEN-1:0] OP_SLL   = 6'd13;
  localparam logic [OPLEN-1:0] OP_SLT   = 6'd14;
  localparam logic [OPLEN-1:0] OP_SLTU  = 6'd15;
  localparam logic [OPLEN-1:0] OP_XOR   = 6'd16;
  localparam logic [OPLEN-1:0] OP_SRL   = 6'd17;
  localparam logic [OPLEN-1:0] OP_SRA   = 6'd18;
  localparam logic [OPLEN-1:0] OP_OR    = 6'd19;
  localparam logic [OPLEN-1:0] OP_AND   = 6'd20;
  localparam logic [OPLEN-1:0] OP_ADDI  = 6'd21;
  localparam logic [OPLEN-1:0] OP_SLTI  = 6'd22;
  localparam logic [OPLEN-1:0] OP_SLTIU = 6'd23;
  localparam logic [OPLEN-1:0] OP_XORI  = 6'd24;
  localparam logic [OPLEN-1:0] OP_ORI   = 6'd25;
  localparam logic [OPLEN-1:0] OP_ANDI  = 6'd26;
  localparam logic [OPLEN-1:0] OP_SLLI  = 6'd27;
  localparam logic [OPLEN-1:0] OP_SRLI  = 6'd28;
  localparam logic [OPLEN-1:0] OP_SRAI  = 6'd29;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} alu_state_e;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  // Register-immediate forms take the immediate as the second operand.
  function automatic logic is_imm_op(input logic [OPLEN-1:0] op);
    case (op)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI: is_imm_op = TRUE;
      default:                   is_imm_op = FALSE;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative shifter: loads an operand and shift amount on start, then moves
// up to SHIFT_STEP bit positions per advancing cycle.
// Ports: clk, rst, rdy (freeze), start (load), advance (take one step),
//        kind (SLL/SRL/SRA), operand, shamt -> done (this step is the last),
//        result (value after this step).
module alu_shifter
  import alu_unit_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        start,
  input  logic        advance,
  input  logic [1:0]  kind,
  input  logic [31:0] operand,
  input  logic [4:0]  shamt,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [5:0] STEP_MAX = 6'(SHIFT_STEP);

  logic [31:0]        data_p1;
  logic signed [31:0] data_s;
  logic [5:0]         rem_p1;
  logic [1:0]         kind_p1;
  logic [5:0]         step_amt;

  assign data_s   = data_p1;
  assign step_amt = (rem_p1 > STEP_MAX) ? STEP_MAX : rem_p1;
  // Final step: what is left fits within a single step.
  assign done     = (rem_p1 != 6'd0) && (rem_p1 <= STEP_MAX);

  always_comb begin
    result = data_p1 << step_amt;
    case (kind_p1)
      SH_SRL:  result = data_p1 >> step_amt;
      SH_SRA:  result = data_s >>> step_amt;
      default: result = data_p1 << step_amt;
    endcase
  end

  // ---- stage p1: remaining count (control) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_p1 <= 6'd0;
    end else if (rdy) begin
      if (start)        rem_p1 <= {1'b0, shamt};
      else if (advance) rem_p1 <= rem_p1 - step_amt;
    end
  end

  // ---- stage p1: shift data ----
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (start) begin
        data_p1 <= operand;
        kind_p1 <= kind;
      end else if (advance) begin
        data_p1 <= result;
      end
    end
  end

endmodule

// File: rtl/alu_unit.sv
// RV32I integer/branch execution unit. Accepts one instruction per cycle from
// the reservation station and broadcasts (rob tag, value, jump, target) on the
// ALU CDB lane. Non-shift ops complete in one cycle; non-zero shifts run on an
// iterative shifter while alu_busy back-pressures the RS.
// Ports: clk, rst (sync, active-high), rdy (global freeze), jump_wrong (flush),
//        alu_enable/alu_op/alu_rs1_value/alu_rs2_value/alu_imm/alu_pc/
//        alu_rd_rename (issue), alu_busy, alu_broadcast/alu_cbd_value/
//        alu_update_rename/alu_jump/alu_jump_target (result lane).
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                jump_wrong,
  input  logic                alu_enable,
  input  logic [OPLEN-1:0]    alu_op,
  input  logic [31:0]         alu_rs1_value,
  input  logic [31:0]         alu_rs2_value,
  input  logic [31:0]         alu_imm,
  input  logic [31:0]         alu_pc,
  input  logic [ROBINDEX-1:0] alu_rd_rename,
  output logic                alu_busy,
  output logic                alu_broadcast,
  output logic [31:0]         alu_cbd_value,
  output logic [ROBINDEX-1:0] alu_update_rename,
  output logic                alu_jump,
  output logic [31:0]         alu_jump_target
);

  alu_state_e state_q, state_d;

  logic [31:0]        op_b, pc4, pc_imm;
  logic signed [31:0] a_s, b_s;
  logic [31:0]        value_c, target_c;
  logic               jump_c, is_shift_c;
  logic [1:0]         kind_c;
  logic [4:0]         shamt_c;
  logic               accept, start_shift, shift_fin;
  logic               sh_done;
  logic [31:0]        sh_result;
  logic [ROBINDEX-1:0] shift_rd_p1;
  logic [31:0]        shift_pc4_p1;

  assign op_b    = is_imm_op(alu_op) ? alu_imm : alu_rs2_value;
  assign a_s     = alu_rs1_value;
  assign b_s     = op_b;
  assign pc4     = alu_pc + 32'd4;
  assign pc_imm  = alu_pc + alu_imm;
  assign shamt_c = op_b[4:0];

  always_comb begin
    value_c    = 32'd0;
    jump_c     = FALSE;
    target_c   = pc4;
    is_shift_c = FALSE;
    kind_c     = SH_SLL;
    case (alu_op)
      OP_ADD, OP_ADDI:   value_c = alu_rs1_value + op_b;
      OP_SUB:            value_c = alu_rs1_value - op_b;
      OP_SLT, OP_SLTI:   value_c = {31'd0, a_s < b_s};
      OP_SLTU, OP_SLTIU: value_c = {31'd0, alu_rs1_value < op_b};
      OP_XOR, OP_XORI:   value_c = alu_rs1_value ^ op_b;
      OP_OR, OP_ORI:     value_c = alu_rs1_value | op_b;
      OP_AND, OP_ANDI:   value_c = alu_rs1_value & op_b;
      // Shift-by-zero completes here with the operand unchanged.
      OP_SLL, OP_SLLI: begin is_shift_c = TRUE; kind_c = SH_SLL; value_c = alu_rs1_value; end
      OP_SRL, OP_SRLI: begin is_shift_c = TRUE; kind_c = SH_SRL; value_c = alu_rs1_value; end
      OP_SRA, OP_SRAI: begin is_shift_c = TRUE; kind_c = SH_SRA; value_c = alu_rs1_value; end
      OP_LUI:            value_c = alu_imm;
      OP_AUIPC:          value_c = pc_imm;
      OP_JAL: begin
        value_c  = pc4;
        jump_c   = TRUE;
        target_c = pc_imm;
      end
      OP_JALR: begin
        value_c  = pc4;
        jump_c   = TRUE;
        target_c = (alu_rs1_value + alu_imm) & ~32'd1;
      end
      OP_BEQ:  jump_c = (alu_rs1_value == op_b);
      OP_BNE:  jump_c = (alu_rs1_value != op_b);
      OP_BLT:  jump_c = (a_s < b_s);
      OP_BGE:  jump_c = (a_s >= b_s);
      OP_BLTU: jump_c = (alu_rs1_value < op_b);
      OP_BGEU: jump_c = (alu_rs1_value >= op_b);
      default: ;
    endcase
    if (jump_c && alu_op != OP_JAL && alu_op != OP_JALR) target_c = pc_imm;
  end

  assign alu_busy    = (state_q == ST_SHIFT);
  assign accept      = (state_q == ST_IDLE) && alu_enable && rdy && !rst && !jump_wrong;
  assign start_shift = accept && is_shift_c && (shamt_c != 5'd0);
  assign shift_fin   = (state_q == ST_SHIFT) && sh_done && rdy && !jump_wrong;

  alu_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .start   (start_shift),
    .advance (state_q == ST_SHIFT),
    .kind    (kind_c),
    .operand (alu_rs1_value),
    .shamt   (shamt_c),
    .done    (sh_done),
    .result  (sh_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_shift) state_d = ST_SHIFT;
      ST_SHIFT: if (jump_wrong || sh_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      state_q <= ST_IDLE;
    else if (rdy) state_q <= state_d;
  end

  // ---- stage p1: in-flight shift tag and fall-through PC ----
  always_ff @(posedge clk) begin
    if (rdy && start_shift) begin
      shift_rd_p1  <= alu_rd_rename;
      shift_pc4_p1 <= pc4;
    end
  end

  // ---- stage p1: CDB output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_broadcast     <= FALSE;
      alu_cbd_value     <= 32'd0;
      alu_update_rename <= ROBNOTRENAME;
      alu_jump          <= FALSE;
      alu_jump_target   <= 32'd0;
    end else if (rdy) begin
      if (jump_wrong) begin
        alu_broadcast <= FALSE;
      end else if (accept && !start_shift) begin
        alu_broadcast     <= TRUE;
        alu_cbd_value     <= value_c;
        alu_update_rename <= alu_rd_rename;
        alu_jump          <= jump_c;
        alu_jump_target   <= target_c;
      end else if (shift_fin) begin
        alu_broadcast     <= TRUE;
        alu_cbd_value     <= sh_result;
        alu_update_rename <= shift_rd_p1;
        alu_jump          <= FALSE;
        alu_jump_target   <= shift_pc4_p1;
      end else begin
        alu_broadcast <= FALSE;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, alu_enable;
  logic [5:0]  alu_op;
  logic [31:0] alu_rs1_value, alu_rs2_value, alu_imm, alu_pc;
  logic [4:0]  alu_rd_rename;
  logic        alu_busy, alu_broadcast, alu_jump;
  logic [31:0] alu_cbd_value, alu_jump_target;
  logic [4:0]  alu_update_rename;

  int n_checks = 0;
  int n_errors = 0;

  // window observation results
  int          w_first_bc, w_nbc, w_nbusy;
  logic [31:0] w_val;
  logic [4:0]  w_tag;
  logic        busy_hist [1:16];
  logic        bc_hist   [1:16];

  always #5 clk = ~clk;

  alu_unit #(.SHIFT_STEP(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .alu_enable(alu_enable), .alu_op(alu_op),
    .alu_rs1_value(alu_rs1_value), .alu_rs2_value(alu_rs2_value),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rd_rename(alu_rd_rename),
    .alu_busy(alu_busy), .alu_broadcast(alu_broadcast),
    .alu_cbd_value(alu_cbd_value), .alu_update_rename(alu_update_rename),
    .alu_jump(alu_jump), .alu_jump_target(alu_jump_target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an op for one edge; returns at the following negedge with enable low.
  task automatic issue(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    alu_op = op; alu_rs1_value = rs1; alu_rs2_value = rs2;
    alu_imm = imm; alu_pc = pc; alu_rd_rename = rd;
    alu_enable = 1'b1;
    @(negedge clk);
    alu_enable = 1'b0;
  endtask

  // Observe n negedges (k=1 is the current one). Optional stimulus: an ADD
  // enable pulse at k=en_k, a flush at k=fl_k, rdy low for 3 cycles from k=rl_k.
  task automatic window(input int n, input int en_k, input int fl_k, input int rl_k);
    w_first_bc = 0; w_nbc = 0; w_nbusy = 0; w_val = 32'hx; w_tag = 5'hx;
    for (int k = 1; k <= n; k++) begin
      busy_hist[k] = alu_busy;
      bc_hist[k]   = alu_broadcast;
      if (alu_busy) w_nbusy++;
      if (alu_broadcast && (rl_k == 0 || rdy)) begin
        w_nbc++;
        if (w_first_bc == 0) begin
          w_first_bc = k; w_val = alu_cbd_value; w_tag = alu_update_rename;
        end
      end
      alu_enable = (k == en_k);
      if (k == en_k) begin
        alu_op = OP_ADD; alu_rs1_value = 32'd1; alu_rs2_value = 32'd1; alu_rd_rename = 5'd3;
      end
      jump_wrong = (k == fl_k);
      rdy = !(rl_k != 0 && k >= rl_k && k < rl_k + 3);
      @(negedge clk);
    end
    alu_enable = 1'b0; jump_wrong = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; alu_enable = 1'b0;
    alu_op = OP_NOP; alu_rs1_value = '0; alu_rs2_value = '0;
    alu_imm = '0; alu_pc = '0; alu_rd_rename = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_bcast",  {31'd0, alu_broadcast}, 32'd0);
    check("rst_value",  alu_cbd_value, 32'd0);
    check("rst_rename", {27'd0, alu_update_rename}, 32'd16);
    check("rst_jump",   {31'd0, alu_jump}, 32'd0);
    check("rst_target", alu_jump_target, 32'd0);
    check("rst_busy",   {31'd0, alu_busy}, 32'd0);

    // ADD 7 + (-3), tag 5
    issue(OP_ADD, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'h200, 5'd5);
    check("add_bcast",  {31'd0, alu_broadcast}, 32'd1);
    check("add_value",  alu_cbd_value, 32'd4);
    check("add_rename", {27'd0, alu_update_rename}, 32'd5);
    check("add_jump",   {31'd0, alu_jump}, 32'd0);
    check("add_target", alu_jump_target, 32'h204);
    @(negedge clk);
    check("add_pulse_end", {31'd0, alu_broadcast}, 32'd0);

    // Signed vs unsigned branch on the same operands
    issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd1);
    check("blt_jump",   {31'd0, alu_jump}, 32'd1);
    check("blt_target", alu_jump_target, 32'h120);
    check("blt_value",  alu_cbd_value, 32'd0);
    issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd2);
    check("bltu_jump",   {31'd0, alu_jump}, 32'd0);
    check("bltu_target", alu_jump_target, 32'h104);

    // JALR clears bit 0 of the target
    issue(OP_JALR, 32'h1003, 32'd0, 32'd4, 32'h40, 5'd4);
    check("jalr_value",  alu_cbd_value, 32'h44);
    check("jalr_target", alu_jump_target, 32'h1006);
    check("jalr_jump",   {31'd0, alu_jump}, 32'd1);

    // SRA 0x80000000 by 9 with an ignored enable while busy
    issue(OP_SRA, 32'h8000_0000, 32'd9, 32'd0, 32'h300, 5'd9);
    window(8, 1, 0, 0);
    check("sra_busy_cycles", w_nbusy, 32'd3);
    check("sra_bcast_count", w_nbc, 32'd1);
    check("sra_bcast_k",     w_first_bc, 32'd4);
    check("sra_value",       w_val, 32'hFFC0_0000);
    check("sra_rename",      {27'd0, w_tag}, 32'd9);

    // SLL by 0 (rs2=32, low bits zero): single cycle, no busy
    issue(OP_SLL, 32'h1234, 32'd32, 32'd0, 32'h400, 5'd6);
    check("sll0_bcast", {31'd0, alu_broadcast}, 32'd1);
    check("sll0_value", alu_cbd_value, 32'h1234);
    check("sll0_busy",  {31'd0, alu_busy}, 32'd0);
    @(negedge clk);
    check("sll0_busy_after", {31'd0, alu_busy}, 32'd0);

    // SLLI through the immediate path: 3 << 5 = 0x60 after 2 cycles
    issue(OP_SLLI, 32'd3, 32'hFFFF_FFFF, 32'd5, 32'h500, 5'd8);
    window(5, 0, 0, 0);
    check("slli_bcast_k", w_first_bc, 32'd3);
    check("slli_value",   w_val, 32'h60);

    // Eight back-to-back ADDs
    alu_op = OP_ADD; alu_rs1_value = 32'd0; alu_rs2_value = 32'd100;
    alu_rd_rename = 5'd0; alu_pc = 32'h600; alu_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_bcast", i),  {31'd0, alu_broadcast}, 32'd1);
      check($sformatf("b2b%0d_rename", i), {27'd0, alu_update_rename}, i);
      check($sformatf("b2b%0d_value", i),  alu_cbd_value, 32'd100 + i);
      alu_rs1_value = i + 1; alu_rd_rename = 5'(i + 1);
      alu_enable = (i < 7);
    end
    @(negedge clk);
    check("b2b_end", {31'd0, alu_broadcast}, 32'd0);

    // SRL by 20, flushed mid-shift
    issue(OP_SRL, 32'hF000_0000, 32'd20, 32'd0, 32'h700, 5'd7);
    window(9, 0, 2, 0);
    check("flush_busy_next", {31'd0, busy_hist[3]}, 32'd0);
    check("flush_bcast_next", {31'd0, bc_hist[3]}, 32'd0);
    check("flush_no_bcast", w_nbc, 32'd0);

    // SRL by 20 with rdy low for 3 cycles mid-shift: broadcast moves k=6 -> k=9
    issue(OP_SRL, 32'hF000_0000, 32'd20, 32'd0, 32'h800, 5'd6);
    window(12, 0, 0, 2);
    check("rdy_bcast_k",     w_first_bc, 32'd9);
    check("rdy_bcast_count", w_nbc, 32'd1);
    check("rdy_value",       w_val, 32'h0000_0F00);
    check("rdy_rename",      {27'd0, w_tag}, 32'd6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
